// File: rtl/if_stage.sv
// Instruction fetch stage.
// Issues at most one instruction-memory request at a time, tracks the fetch
// PC and hands fetched instructions to the if_id pipeline register.
// Ports:
//   clock, resetn            - clock and asynchronous active-low reset
//   stall_in                 - downstream hold request
//   redirect_in/_pc_in       - taken branch/jump: flush and refetch from target
//   imem_req/addr/ready      - fetch request handshake
//   imem_rvalid/rdata        - fetch response
//   pc_out, inst_out         - PC and instruction for if_id
//   p_ctrl_out               - if_id control: bit0 = hold, bit1 = load bubble
module if_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INST = 32'h0000_0013
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            stall_in,
  input  logic            redirect_in,
  input  logic [XLEN-1:0] redirect_pc_in,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] pc_out,
  output logic [31:0]     inst_out,
  output logic [1:0]      p_ctrl_out
);

  typedef enum logic [2:0] {StIdle, StFetch, StWait, StKill, StHold} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [31:0]     hold_inst_q, hold_inst_d;

  logic            inst_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] fpc_inc;
  logic [XLEN-1:0] reset_pc;

  // Fetch addresses are always word aligned.
  assign redirect_pc = {redirect_pc_in[XLEN-1:2], 2'b00};
  assign reset_pc    = {RESET_PC[XLEN-1:2], 2'b00};
  assign fpc_inc     = fpc_q + XLEN'(4);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      fpc_q       <= reset_pc;
      hold_inst_q <= NOP_INST;
    end else begin
      state_q     <= state_d;
      fpc_q       <= fpc_d;
      hold_inst_q <= hold_inst_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fpc_d       = fpc_q;
    hold_inst_d = hold_inst_q;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (redirect_in) begin
          fpc_d = redirect_pc;
        end else if (imem_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (redirect_in) begin
          fpc_d = redirect_pc;
          // A response in the same cycle closes the request; otherwise it is
          // still in flight and must be drained in StKill.
          state_d = imem_rvalid ? StFetch : StKill;
        end else if (imem_rvalid) begin
          if (stall_in) begin
            hold_inst_d = imem_rdata;
            state_d     = StHold;
          end else begin
            fpc_d   = fpc_inc;
            state_d = StFetch;
          end
        end
      end
      StKill: begin
        if (redirect_in) begin
          fpc_d = redirect_pc;
        end
        if (imem_rvalid) begin
          state_d = StFetch;
        end
      end
      StHold: begin
        if (redirect_in) begin
          fpc_d   = redirect_pc;
          state_d = StFetch;
        end else if (!stall_in) begin
          fpc_d   = fpc_inc;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign inst_valid = ((state_q == StWait) && imem_rvalid) || (state_q == StHold);

  assign imem_req  = (state_q == StFetch) && !redirect_in;
  assign imem_addr = fpc_q;
  assign pc_out    = fpc_q;

  always_comb begin
    inst_out = NOP_INST;
    unique case (state_q)
      StWait:  inst_out = imem_rdata;
      StHold:  inst_out = hold_inst_q;
      default: inst_out = NOP_INST;
    endcase
  end

  // Hold is masked while in reset so if_id sees a plain bubble.
  assign p_ctrl_out[0] = stall_in && !redirect_in && resetn;
  assign p_ctrl_out[1] = redirect_in || !inst_valid;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clock;
  logic        resetn;
  logic        stall_in;
  logic        redirect_in;
  logic [31:0] redirect_pc_in;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic [1:0]  p_ctrl_out;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } xfer_t;

  xfer_t sb[$];
  int    checks = 0;
  int    errors = 0;

  if_stage dut (
    .clock          (clock),
    .resetn         (resetn),
    .stall_in       (stall_in),
    .redirect_in    (redirect_in),
    .redirect_pc_in (redirect_pc_in),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .pc_out         (pc_out),
    .inst_out       (inst_out),
    .p_ctrl_out     (p_ctrl_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h5A3C_0093;
  endfunction

  // Transfer monitor: every if_id load (p_ctrl 00) must match the oldest
  // expected transfer pushed by the stimulus.
  always begin
    xfer_t e;
    @(negedge clock);
    #3;
    if (resetn === 1'b1 && p_ctrl_out === 2'b00) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_xfer got pc=%h inst=%h want none", pc_out, inst_out);
      end else begin
        e = sb.pop_front();
        if (pc_out !== e.pc || inst_out !== e.inst) begin
          errors++;
          $display("FAIL xfer got pc=%h inst=%h want pc=%h inst=%h",
                   pc_out, inst_out, e.pc, e.inst);
        end
      end
    end
  end

  task automatic quiet();
    stall_in       = 1'b0;
    redirect_in    = 1'b0;
    redirect_pc_in = '0;
    imem_ready     = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'hDEAD_BEEF;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    quiet();
    stall_in = 1'b1;
    @(negedge clock);
    #2;
    checks++;
    if (imem_req !== 1'b0 || inst_out !== Nop || p_ctrl_out !== 2'b10) begin
      errors++;
      $display("FAIL reset_outputs got req=%b inst=%h ctrl=%b want 0 %h 10",
               imem_req, inst_out, p_ctrl_out, Nop);
    end
    @(negedge clock);
    quiet();
    resetn = 1'b1;
    #2;
    checks++;
    if (imem_req !== 1'b0 || p_ctrl_out !== 2'b10) begin
      errors++;
      $display("FAIL idle_after_release got req=%b ctrl=%b want 0 10", imem_req, p_ctrl_out);
    end
    @(negedge clock);
    #2;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL first_req got req=%b addr=%h want 1 00000000", imem_req, imem_addr);
    end
  endtask

  // Starts in FETCH at fpc 0.
  task automatic test_basic();
    imem_ready = 1'b1;
    #2;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || p_ctrl_out !== 2'b10) begin
      errors++;
      $display("FAIL basic_req got req=%b addr=%h ctrl=%b want 1 0 10",
               imem_req, imem_addr, p_ctrl_out);
    end
    @(negedge clock);
    quiet();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0050_0093;
    sb.push_back('{pc: 32'h0, inst: 32'h0050_0093});
    #2;
    checks++;
    if (p_ctrl_out !== 2'b00 || inst_out !== 32'h0050_0093) begin
      errors++;
      $display("FAIL basic_xfer got ctrl=%b inst=%h want 00 00500093", p_ctrl_out, inst_out);
    end
    @(negedge clock);
    quiet();
    #2;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      errors++;
      $display("FAIL basic_next got req=%b addr=%h want 1 00000004", imem_req, imem_addr);
    end
  endtask

  // Starts in FETCH at fpc 4.
  task automatic test_hold();
    logic [31:0] d;
    d = mem(32'h4);
    imem_ready = 1'b1;
    @(negedge clock);
    quiet();
    imem_rvalid = 1'b1;
    imem_rdata  = d;
    stall_in    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if (p_ctrl_out !== 2'b01 || inst_out !== d || pc_out !== 32'h4) begin
        errors++;
        $display("FAIL hold_cycle%0d got ctrl=%b inst=%h pc=%h want 01 %h 4",
                 i, p_ctrl_out, inst_out, pc_out, d);
      end
      @(negedge clock);
      // Stray response data while holding must not disturb the held word.
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD0_0000 + 32'(i);
    end
    quiet();
    sb.push_back('{pc: 32'h4, inst: d});
    #2;
    checks++;
    if (p_ctrl_out !== 2'b00) begin
      errors++;
      $display("FAIL hold_release got ctrl=%b want 00", p_ctrl_out);
    end
    @(negedge clock);
    quiet();
    imem_rvalid = 1'b1;
    #2;
    checks++;
    if (imem_addr !== 32'h8 || imem_req !== 1'b1 || p_ctrl_out !== 2'b10) begin
      errors++;
      $display("FAIL hold_next got addr=%h req=%b ctrl=%b want 8 1 10",
               imem_addr, imem_req, p_ctrl_out);
    end
    imem_rvalid = 1'b0;
  endtask

  // Starts in FETCH at fpc 8.
  task automatic test_kill();
    imem_ready = 1'b1;
    @(negedge clock);
    quiet();
    redirect_in    = 1'b1;
    redirect_pc_in = 32'h0000_0103;
    #2;
    checks++;
    if (p_ctrl_out !== 2'b10 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL kill_redirect got ctrl=%b req=%b want 10 0", p_ctrl_out, imem_req);
    end
    @(negedge clock);
    quiet();
    #2;
    checks++;
    if (p_ctrl_out !== 2'b10 || imem_req !== 1'b0 || imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL kill_wait got ctrl=%b req=%b addr=%h want 10 0 100",
               p_ctrl_out, imem_req, imem_addr);
    end
    @(negedge clock);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD1_1111;
    #2;
    checks++;
    if (p_ctrl_out !== 2'b10 || inst_out !== Nop) begin
      errors++;
      $display("FAIL kill_drop got ctrl=%b inst=%h want 10 %h", p_ctrl_out, inst_out, Nop);
    end
    @(negedge clock);
    quiet();
    imem_ready = 1'b1;
    #2;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || p_ctrl_out !== 2'b10) begin
      errors++;
      $display("FAIL kill_refetch got req=%b addr=%h ctrl=%b want 1 100 10",
               imem_req, imem_addr, p_ctrl_out);
    end
    @(negedge clock);
    quiet();
    imem_rvalid = 1'b1;
    imem_rdata  = mem(32'h100);
    sb.push_back('{pc: 32'h100, inst: mem(32'h100)});
    @(negedge clock);
    quiet();
  endtask

  // Starts in FETCH at fpc 0x104.
  task automatic test_fetch_redirect();
    redirect_in    = 1'b1;
    redirect_pc_in = 32'h0000_0200;
    imem_ready     = 1'b1;
    #2;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h104) begin
      errors++;
      $display("FAIL fetch_redirect_req got req=%b addr=%h want 0 104", imem_req, imem_addr);
    end
    @(negedge clock);
    quiet();
    #2;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      errors++;
      $display("FAIL fetch_redirect_addr got req=%b addr=%h want 1 200", imem_req, imem_addr);
    end
  endtask

  // Starts in FETCH at fpc 0x200.
  task automatic test_hold_redirect();
    imem_ready = 1'b1;
    @(negedge clock);
    quiet();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD2_2222;
    stall_in    = 1'b1;
    @(negedge clock);
    quiet();
    stall_in       = 1'b1;
    redirect_in    = 1'b1;
    redirect_pc_in = 32'h0000_0300;
    #2;
    checks++;
    if (p_ctrl_out !== 2'b10) begin
      errors++;
      $display("FAIL hold_redirect_ctrl got %b want 10", p_ctrl_out);
    end
    @(negedge clock);
    quiet();
    #2;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h300 || p_ctrl_out !== 2'b10) begin
      errors++;
      $display("FAIL hold_redirect_next got req=%b addr=%h ctrl=%b want 1 300 10",
               imem_req, imem_addr, p_ctrl_out);
    end
  endtask

  // Redirect coinciding with a response: data dropped, refetch from target.
  task automatic test_wait_redirect_rvalid();
    imem_ready = 1'b1;
    @(negedge clock);
    quiet();
    imem_rvalid    = 1'b1;
    imem_rdata     = 32'hBAD3_3333;
    redirect_in    = 1'b1;
    redirect_pc_in = 32'hFFFF_FFFE;
    #2;
    checks++;
    if (p_ctrl_out !== 2'b10) begin
      errors++;
      $display("FAIL wait_redirect_ctrl got %b want 10", p_ctrl_out);
    end
    @(negedge clock);
    quiet();
    #2;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wait_redirect_addr got req=%b addr=%h want 1 fffffffc",
               imem_req, imem_addr);
    end
  endtask

  // Starts in FETCH at fpc 0xFFFFFFFC.
  task automatic test_wrap();
    imem_ready = 1'b1;
    @(negedge clock);
    quiet();
    imem_rvalid = 1'b1;
    imem_rdata  = mem(32'hFFFF_FFFC);
    sb.push_back('{pc: 32'hFFFF_FFFC, inst: mem(32'hFFFF_FFFC)});
    @(negedge clock);
    quiet();
    #2;
    checks++;
    if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL wrap_addr got addr=%h req=%b want 0 1", imem_addr, imem_req);
    end
  endtask

  // Starts in FETCH at fpc 0: four consecutive fetches with no gaps.
  task automatic test_back_to_back();
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      a = 32'(i) * 32'd4;
      imem_ready = 1'b1;
      #2;
      checks++;
      if (imem_addr !== a || imem_req !== 1'b1) begin
        errors++;
        $display("FAIL b2b_addr%0d got addr=%h req=%b want %h 1", i, imem_addr, imem_req, a);
      end
      @(negedge clock);
      quiet();
      imem_rvalid = 1'b1;
      imem_rdata  = mem(a);
      sb.push_back('{pc: a, inst: mem(a)});
      @(negedge clock);
      quiet();
    end
  endtask

  // Starts in FETCH at fpc 0x10.
  task automatic test_reset_mid_wait();
    imem_ready = 1'b1;
    @(negedge clock);
    quiet();
    resetn = 1'b0;
    #2;
    checks++;
    if (imem_req !== 1'b0 || p_ctrl_out !== 2'b10 || inst_out !== Nop) begin
      errors++;
      $display("FAIL rst_wait got req=%b ctrl=%b inst=%h want 0 10 %h",
               imem_req, p_ctrl_out, inst_out, Nop);
    end
    @(negedge clock);
    resetn      = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD4_4444;
    #2;
    checks++;
    if (p_ctrl_out !== 2'b10) begin
      errors++;
      $display("FAIL rst_late_idle got ctrl=%b want 10", p_ctrl_out);
    end
    @(negedge clock);
    #2;
    checks++;
    if (p_ctrl_out !== 2'b10 || imem_addr !== 32'h0 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_late_fetch got ctrl=%b addr=%h req=%b want 10 0 1",
               p_ctrl_out, imem_addr, imem_req);
    end
    @(negedge clock);
    quiet();
    imem_ready = 1'b1;
    @(negedge clock);
    quiet();
    imem_rvalid = 1'b1;
    imem_rdata  = mem(32'h0);
    sb.push_back('{pc: 32'h0, inst: mem(32'h0)});
    @(negedge clock);
    quiet();
  endtask

  initial begin
    quiet();
    resetn = 1'b0;
    test_reset();
    test_basic();
    test_hold();
    test_kill();
    test_fetch_redirect();
    test_hold_redirect();
    test_wait_redirect_rvalid();
    test_wrap();
    test_back_to_back();
    test_reset_mid_wait();
    repeat (2) @(negedge clock);
    #4;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
